stream_window_3: RTL and testbench
==================================

Name: stream_window_3

Overview:
- Producer side of the 3x3 window interface used by the stream convolution kernels.
- Accepts a raster-order pixel stream, one pixel per accepted cycle, and keeps two line buffers of WIDTH entries.
- Emits a registered 3x3 neighbourhood plus a valid strobe and centre coordinates, ready to feed any stream_kernel instance.
- Windows are only flagged valid when all 9 taps belong to the current frame.

Parameters:
PRECISION, 16, signed pixel/tap width
WIDTH, 640, pixels per line
HEIGHT, 480, lines per frame

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  pixel_in/in_sof accepted this cycle when 1
in_sof  input  1  start of frame; qualified by in_valid
pixel_in  input  PRECISION signed  incoming pixel
window  output  [2:0][2:0] x PRECISION signed  neighbourhood; [0][*] = oldest row (y-1), [*][0] = leftmost (x-1)
out_valid  output  1  window is a complete in-frame neighbourhood
out_x  output  $clog2(WIDTH)  centre column of window
out_y  output  $clog2(HEIGHT)  centre row of window
out_eof  output  1  pulses with the last window of the frame

Behaviour:
- Reset (reset=0, asynchronous):
  - col=0, row=0.
  - window all 0, out_valid=0, out_eof=0, out_x=0, out_y=0.
  - Line buffer RAM is not cleared.
- Idle cycle (in_valid=0):
  - No state changes; outputs hold.
  - out_valid and out_eof drop to 0.
- Accepted cycle (in_valid=1):
  - Effective position (c,r) = (0,0) if in_sof=1, else the current (col,row).
  - Window shift: window[i][0]<=window[i][1]; window[i][1]<=window[i][2], for i=0..2.
  - New column: window[0][2]<=line1[c]; window[1][2]<=line0[c]; window[2][2]<=pixel_in.
  - Line buffers: line1[c]<=line0[c]; line0[c]<=pixel_in. Read-before-write at the same address.
  - Counters: col<=c+1; at c=WIDTH-1, col<=0 and row<=r+1; at r=HEIGHT-1 and c=WIDTH-1, row<=0.
- Outputs, latency 1 cycle after the accepted pixel:
  - out_valid<=(c>=2 && r>=2); out_x<=c-1; out_y<=r-1.
  - out_eof<=(c==WIDTH-1 && r==HEIGHT-1).
  - out_x/out_y update on every accepted cycle. They are meaningful only while out_valid=1.
- Boundary rules:
  - Columns 0,1 of each row: window holds the previous row's right edge, out_valid=0.
  - Rows 0,1: line buffers may hold the previous frame's data, out_valid=0. Stale data is never flagged valid.
  - Valid windows per frame = (WIDTH-2)*(HEIGHT-2); no padded borders.
  - in_sof mid-frame: the frame restarts immediately and the partial frame is abandoned. No out_eof is produced for the abandoned frame.
  - in_sof without in_valid: ignored.
  - Reset mid-frame: outputs go to reset values at once. The next accepted pixel is (0,0) regardless of in_sof.
  - Pixel values pass through unmodified; no arithmetic on data.
- Implementation: line buffers as inferred single-port-read/single-port-write RAM, one read and one write per cycle.

Test Plan:
All tests use WIDTH=4, HEIGHT=4, PRECISION=16, pixel = 16*y+x.
1. Continuous 16-pixel frame with in_sof on the first pixel -> exactly 4 out_valid pulses. The first pulse comes the cycle after pixel 34 with window rows {0,1,2},{16,17,18},{32,33,34}, out_x=1, out_y=1. The last window has out_x=2, out_y=2, window[2][2]=51 and out_eof=1 in the same cycle.
2. Same frame with in_valid toggled 1,0,0,1,... -> identical 4 windows and coordinates; out_valid never high on the cycle after an idle cycle.
3. Frame 1 values followed by frame 2 with values +100 -> frame-2 windows contain only frame-2 values (first window [0][0]=100); no out_valid during frame-2 rows 0,1.
4. in_sof asserted on pixel index 9 (value 0x0F00) -> that pixel is treated as (0,0). No out_valid until the restarted frame reaches (2,2); no out_eof for the abandoned frame.
5. reset pulled low for 1 cycle mid-row 2 (asynchronous, between edges) -> window, out_valid, out_x and out_y are 0 immediately. A fresh 16-pixel frame then produces the same 4 windows as test 1.
6. Pixel values -1 and -32768 at position (2,2) -> window[2][2] reads back bit-exact, sign preserved.

Source files
------------

// File: rtl/stream_window_3.sv
// 3x3 raster-stream window generator: two line buffers plus a 3x3 shift register,
// with centre coordinates and a valid strobe only when all nine taps are in-frame.
module stream_window_3 #(
    parameter int unsigned PRECISION = 16,
    parameter int unsigned WIDTH     = 640,
    parameter int unsigned HEIGHT    = 480
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    input  logic                                   in_sof,
    input  logic signed [PRECISION-1:0]            pixel_in,
    output logic signed [2:0][2:0][PRECISION-1:0]  window,
    output logic                                   out_valid,
    output logic        [$clog2(WIDTH)-1:0]        out_x,
    output logic        [$clog2(HEIGHT)-1:0]       out_y,
    output logic                                   out_eof
);

    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic [XW-1:0] col;
    logic [YW-1:0] row;

    logic [XW-1:0] c_eff_c;
    logic [YW-1:0] r_eff_c;
    logic [XW-1:0] col_next_c;
    logic [YW-1:0] row_next_c;
    logic          valid_next_c;
    logic          eof_next_c;

    logic signed [PRECISION-1:0] line0 [WIDTH];
    logic signed [PRECISION-1:0] line1 [WIDTH];
    logic signed [PRECISION-1:0] rd0_c;
    logic signed [PRECISION-1:0] rd1_c;

    // Effective position, line buffer reads and next counter/flag values
    always_comb begin
        c_eff_c      = in_sof ? '0 : col;
        r_eff_c      = in_sof ? '0 : row;
        rd0_c        = line0[c_eff_c];
        rd1_c        = line1[c_eff_c];
        col_next_c   = c_eff_c + XW'(1);
        row_next_c   = r_eff_c;
        if (c_eff_c == X_LAST) begin
            col_next_c = '0;
            row_next_c = (r_eff_c == Y_LAST) ? '0 : r_eff_c + YW'(1);
        end
        valid_next_c = (c_eff_c >= XW'(2)) && (r_eff_c >= YW'(2));
        eof_next_c   = (c_eff_c == X_LAST) && (r_eff_c == Y_LAST);
    end

    // Line buffers: no reset, read-before-write at the same column
    always_ff @(posedge clk) begin
        if (in_valid && reset) begin
            line1[c_eff_c] <= rd0_c;
            line0[c_eff_c] <= pixel_in;
        end
    end

    // Position counters, window shift register and output flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col       <= '0;
            row       <= '0;
            window    <= '0;
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
        end else if (in_valid) begin
            col <= col_next_c;
            row <= row_next_c;
            for (int i = 0; i < 3; i++) begin
                window[i][0] <= window[i][1];
                window[i][1] <= window[i][2];
            end
            window[0][2] <= rd1_c;
            window[1][2] <= rd0_c;
            window[2][2] <= pixel_in;
            out_valid    <= valid_next_c;
            out_eof      <= eof_next_c;
            out_x        <= c_eff_c - XW'(1);
            out_y        <= r_eff_c - YW'(1);
        end else begin
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_window_3.sv
// Directed bench for stream_window_3 on a 4x4 frame: vector tables built from a
// frame image, plus hand sequences for async reset and per-frame pulse counts.
module tb_stream_window_3;

    localparam int unsigned PREC = 16;
    localparam int unsigned W    = 4;
    localparam int unsigned H    = 4;

    typedef logic signed [2:0][2:0][PREC-1:0] win_t;

    typedef struct {
        int          tid;
        logic        v;
        logic        s;
        logic [15:0] pix;
        logic        ev;
        logic        eeof;
        logic [1:0]  ex;
        logic [1:0]  ey;
        win_t        ew;
    } vec_t;

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_sof;
    logic signed [15:0]   pixel_in;
    win_t                 window;
    logic                 out_valid;
    logic [1:0]           out_x;
    logic [1:0]           out_y;
    logic                 out_eof;

    int          checks;
    int          errors;
    int          obs_valid [6];
    int          obs_eof   [6];
    win_t        cap11     [6];
    logic [15:0] q22 [$];
    vec_t        q   [$];

    stream_window_3 #(.PRECISION(PREC), .WIDTH(W), .HEIGHT(H)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .pixel_in (pixel_in),
        .window   (window),
        .out_valid(out_valid),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_eof  (out_eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_win(input string name, input win_t act, input win_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Frame image model: pixel = base + 16*y + x, optional override at (2,2)
    task automatic add_frame(input int tid, input int base, input bit sof, input int gaps,
                             input int npix, input bit use_sp, input logic [15:0] sp);
        logic [15:0] img [4][4];
        vec_t        v;
        for (int idx = 0; idx < npix; idx++) begin
            int x;
            int y;
            x = idx % 4;
            y = idx / 4;
            img[y][x] = (use_sp && x == 2 && y == 2) ? sp : 16'(base + 16 * y + x);
            v.tid  = tid;
            v.v    = 1'b1;
            v.s    = sof && (idx == 0);
            v.pix  = img[y][x];
            v.ev   = (x >= 2) && (y >= 2);
            v.eeof = (x == 3) && (y == 3);
            v.ex   = 2'(x - 1);
            v.ey   = 2'(y - 1);
            v.ew   = '0;
            if (v.ev) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        v.ew[i][j] = img[y - 2 + i][x - 2 + j];
            end
            q.push_back(v);
            if (idx != npix - 1) begin
                for (int g = 0; g < gaps; g++) begin
                    v.v    = 1'b0;
                    v.s    = 1'b1;
                    v.pix  = 16'hDEAD;
                    v.ev   = 1'b0;
                    v.eeof = 1'b0;
                    v.ew   = '0;
                    q.push_back(v);
                end
            end
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        in_valid = v.v;
        in_sof   = v.s;
        pixel_in = v.pix;
        @(posedge clk);
        #1;
        chk($sformatf("t%0d out_valid", v.tid), 32'(out_valid), 32'(v.ev));
        chk($sformatf("t%0d out_eof", v.tid), 32'(out_eof), 32'(v.eeof));
        if (v.ev) begin
            chk($sformatf("t%0d out_x", v.tid), 32'(out_x), 32'(v.ex));
            chk($sformatf("t%0d out_y", v.tid), 32'(out_y), 32'(v.ey));
            chk_win($sformatf("t%0d window", v.tid), window, v.ew);
        end
        if (out_valid) obs_valid[v.tid]++;
        if (out_eof) obs_eof[v.tid]++;
        if (out_valid && out_x == 2'd1 && out_y == 2'd1) begin
            cap11[v.tid] = window;
            if (v.tid == 5) q22.push_back(window[2][2]);
        end
    endtask

    task automatic run_q();
        foreach (q[k]) apply(q[k]);
        q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int   exp_v [6];
        int   exp_e [6];
        win_t lit;

        exp_v = '{4, 4, 8, 4, 5, 8};
        exp_e = '{1, 1, 2, 1, 1, 2};
        lit[0] = {16'd2, 16'd1, 16'd0};
        lit[1] = {16'd18, 16'd17, 16'd16};
        lit[2] = {16'd34, 16'd33, 16'd32};

        checks    = 0;
        errors    = 0;
        obs_valid = '{default: 0};
        obs_eof   = '{default: 0};
        cap11     = '{default: '0};
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        pixel_in  = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_eof", 32'(out_eof), 32'd0);
        chk("reset out_x", 32'(out_x), 32'd0);
        chk("reset out_y", 32'(out_y), 32'd0);
        chk_win("reset window", window, '0);
        @(negedge clk);
        reset = 1'b1;

        // 1: continuous frame
        add_frame(0, 0, 1'b1, 0, 16, 1'b0, 16'h0);
        run_q();
        // 2: valid pattern 1,0,0 with in_sof held high on idle cycles
        add_frame(1, 0, 1'b1, 2, 16, 1'b0, 16'h0);
        run_q();
        // 3: two consecutive frames, second offset by 100
        add_frame(2, 0, 1'b1, 0, 16, 1'b0, 16'h0);
        add_frame(2, 100, 1'b1, 0, 16, 1'b0, 16'h0);
        run_q();
        // 4: restart on pixel index 9 with value 0x0F00
        add_frame(3, 0, 1'b1, 0, 9, 1'b0, 16'h0);
        add_frame(3, 16'h0F00, 1'b1, 0, 16, 1'b0, 16'h0);
        run_q();

        // 5: async reset between edges right after the (2,2) window
        add_frame(4, 0, 1'b1, 0, 11, 1'b0, 16'h0);
        run_q();
        #1;
        reset = 1'b0;
        #1;
        chk("async reset out_valid", 32'(out_valid), 32'd0);
        chk("async reset out_x", 32'(out_x), 32'd0);
        chk("async reset out_y", 32'(out_y), 32'd0);
        chk_win("async reset window", window, '0);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #2;
        reset = 1'b1;
        add_frame(4, 0, 1'b0, 0, 16, 1'b0, 16'h0);
        run_q();

        // 6: extreme signed values at (2,2)
        add_frame(5, 0, 1'b1, 0, 16, 1'b1, 16'hFFFF);
        add_frame(5, 0, 1'b1, 0, 16, 1'b1, 16'h8000);
        run_q();

        for (int t = 0; t < 6; t++) begin
            chk($sformatf("t%0d valid pulses", t), 32'(obs_valid[t]), 32'(exp_v[t]));
            chk($sformatf("t%0d eof pulses", t), 32'(obs_eof[t]), 32'(exp_e[t]));
        end
        chk_win("t0 first window", cap11[0], lit);
        chk_win("t4 first window after reset", cap11[4], lit);
        chk("t2 frame2 tap00", 32'(cap11[2][0][0]), 32'd100);
        chk("t3 restart tap00", 32'(cap11[3][0][0]), 32'h0F00);
        chk("t5 captures", 32'(q22.size()), 32'd2);
        if (q22.size() == 2) begin
            chk("t5 tap22 minus one", 32'(q22[0]), 32'h0000FFFF);
            chk("t5 tap22 most negative", 32'(q22[1]), 32'h00008000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
